// File: rtl/reg_sp_deser.sv
// Serial-in/parallel-out receiver, MSB first, with valid/ready output and sticky overflow.
// Define REG_SP_PARITY_EN to expect a trailing even-parity bit after each data word.
module reg_sp_deser #(
  parameter int WIDTH = 4,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             shift_in,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             out_ready,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             overflow,
  output logic [CW-1:0]    bit_count,
  output logic [WIDTH-1:0] reg_content,
  output logic             parity_err
);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] word_next;
  logic [WIDTH-1:0] word_done;
  logic             last_data;
  logic             complete;
  logic             accept;

  assign word_next   = {sreg[WIDTH-2:0], shift_in};
  assign last_data   = shift_en && (bit_count == CW'(WIDTH - 1));
  assign accept      = !out_valid || out_ready;
  assign reg_content = sreg;

`ifdef REG_SP_PARITY_EN
  // state | meaning
  // RECV  | collecting data bits
  // PAR   | full word in sreg, waiting for the even-parity bit
  typedef enum logic {RECV, PAR} state_t;
  state_t state;

  assign complete  = shift_en && (state == PAR);
  assign word_done = sreg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RECV;
      sreg         <= '0;
      bit_count    <= '0;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overflow     <= 1'b0;
      parity_err   <= 1'b0;
    end else if (clear) begin
      state      <= RECV;
      sreg       <= '0;
      bit_count  <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (shift_en) begin
        case (state)
          RECV: begin
            sreg <= word_next;
            if (last_data) begin
              bit_count <= CW'(WIDTH);
              state     <= PAR;
            end else begin
              bit_count <= bit_count + 1'b1;
            end
          end
          PAR: begin
            // parity bit is not shifted in so reg_content keeps showing the word
            bit_count <= '0;
            state     <= RECV;
          end
          default: state <= RECV;
        endcase
      end
      if (complete) begin
        if (accept) begin
          parallel_out <= word_done;
          out_valid    <= 1'b1;
          parity_err   <= (^sreg) ^ shift_in;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end
`else
  assign complete   = last_data;
  assign word_done  = word_next;
  assign parity_err = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg         <= '0;
      bit_count    <= '0;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overflow     <= 1'b0;
    end else if (clear) begin
      sreg      <= '0;
      bit_count <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (shift_en) begin
        sreg      <= word_next;
        bit_count <= last_data ? '0 : bit_count + 1'b1;
      end
      // a stalled consumer keeps the old word; the new one is lost
      if (complete) begin
        if (accept) begin
          parallel_out <= word_done;
          out_valid    <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_sp_deser.sv
// Bench for reg_sp_deser: queue-based word model, per-cycle compare, directed and random stimulus.
module tb_reg_sp_deser;
  localparam int W = 4;
  localparam int CW = $clog2(W + 1);
`ifdef REG_SP_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          shift_in, shift_en, clear, out_ready;
  logic [W-1:0]  parallel_out, reg_content;
  logic          out_valid, overflow, parity_err;
  logic [CW-1:0] bit_count;

  reg_sp_deser #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .shift_in(shift_in), .shift_en(shift_en),
    .clear(clear), .out_ready(out_ready), .parallel_out(parallel_out),
    .out_valid(out_valid), .overflow(overflow), .bit_count(bit_count),
    .reg_content(reg_content), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // model: bits of the current word, last W data bits seen, output holding register
  bit   bitq[$];
  int   m_view, m_pout, m_valid, m_ovf, m_perr;

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void m_reset();
    bitq.delete();
    m_view = 0; m_pout = 0; m_valid = 0; m_ovf = 0; m_perr = 0;
  endfunction

  function automatic void m_clock(bit se, bit b, bit rdy, bit clr);
    int vnext, word, p, need;
    if (clr) begin
      bitq.delete();
      m_view = 0; m_valid = 0; m_ovf = 0; m_perr = 0;
      return;
    end
    vnext = (m_valid != 0 && rdy) ? 0 : m_valid;
    need  = PAR_EN ? W + 1 : W;
    if (se) begin
      if (!(PAR_EN && bitq.size() == W))
        m_view = ((m_view << 1) | int'(b)) % (1 << W);
      bitq.push_back(b);
      if (bitq.size() == need) begin
        word = 0; p = 0;
        for (int i = 0; i < W; i++) word = word * 2 + int'(bitq[i]);
        for (int i = 0; i < need; i++) p = p ^ int'(bitq[i]);
        bitq.delete();
        if (m_valid == 0 || rdy) begin
          m_pout = word; vnext = 1; m_perr = PAR_EN ? p : 0;
        end else begin
          m_ovf = 1;
        end
      end
    end
    m_valid = vnext;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("parallel_out", int'(parallel_out), m_pout);
      chk("out_valid",    int'(out_valid),    m_valid);
      chk("overflow",     int'(overflow),     m_ovf);
      chk("bit_count",    int'(bit_count),    bitq.size());
      chk("reg_content",  int'(reg_content),  m_view);
      chk("parity_err",   int'(parity_err),   m_perr);
    end
  end

  task automatic step(input bit se, input bit b, input bit rdy, input bit clr);
    shift_en = se; shift_in = b; out_ready = rdy; clear = clr;
    @(posedge clk);
    m_clock(se, b, rdy, clr);
    @(negedge clk);
  endtask

  task automatic send_word(input int word, input bit rdy_last);
    for (int i = W - 1; i >= 0; i--) step(1'b1, word[i], (i == 0) ? rdy_last : 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    reset_n = 1'b0;
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; shift_in = 1'b0; shift_en = 1'b0; clear = 1'b0; out_ready = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_pout", int'(parallel_out), 0);

`ifndef REG_SP_PARITY_EN
    // 1: bits 1,0,1,1 with consumer stalled
    step(1, 1, 0, 0); chk("t1_bc1", int'(bit_count), 1);
    step(1, 0, 0, 0); chk("t1_bc2", int'(bit_count), 2);
    step(1, 1, 0, 0); chk("t1_bc3", int'(bit_count), 3);
    step(1, 1, 0, 0); chk("t1_bc0", int'(bit_count), 0);
    chk("t1_pout", int'(parallel_out), 'b1011);
    chk("t1_valid", int'(out_valid), 1);
    // 2: gapped input
    step(0, 0, 0, 1);
    step(1, 0, 0, 0); step(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0); chk("t2_gap_view", int'(reg_content), 'b0001);
    end
    step(1, 1, 0, 0); step(1, 0, 0, 0);
    chk("t2_pout", int'(parallel_out), 'b0110);
    // 3: overflow
    step(0, 0, 0, 1);
    send_word('hA, 0);
    send_word('h5, 0);
    chk("t3_pout_held", int'(parallel_out), 'hA);
    chk("t3_ovf", int'(overflow), 1);
    step(0, 0, 1, 0);
    chk("t3_valid_drop", int'(out_valid), 0);
    chk("t3_ovf_sticky", int'(overflow), 1);
    // 4: back-to-back with no gap
    step(0, 0, 0, 1);
    send_word('h3, 0);
    send_word('hC, 1);
    chk("t4_valid", int'(out_valid), 1);
    chk("t4_pout", int'(parallel_out), 'hC);
    // 5: clear mid-word with overflow and valid set
    send_word('h9, 0);
    step(1, 1, 0, 0); step(1, 0, 0, 0);
    chk("t5_pre_ovf", int'(overflow), 1);
    step(1, 1, 0, 1);
    chk("t5_bc", int'(bit_count), 0);
    chk("t5_valid", int'(out_valid), 0);
    chk("t5_ovf", int'(overflow), 0);
    send_word('hF, 0);
    chk("t5_pout", int'(parallel_out), 'hF);
`else
    // 6: parity good then bad
    send_word('hB, 0);
    step(1, 1, 0, 0);
    chk("t6_pout", int'(parallel_out), 'hB);
    chk("t6_perr0", int'(parity_err), 0);
    send_word('hB, 0);
    step(1, 0, 1, 0);
    chk("t6_perr1", int'(parity_err), 1);
    chk("t6_valid", int'(out_valid), 1);
`endif

    // asynchronous reset mid-word, checked between clock edges
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    #2;
    chk_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("arst_pout", int'(parallel_out), 0);
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_ovf", int'(overflow), 0);
    chk("arst_bc", int'(bit_count), 0);
    chk("arst_view", int'(reg_content), 0);
    chk("arst_perr", int'(parity_err), 0);
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1'b1;
    step(1, 1, 0, 0);
    chk("arst_restart_bc", int'(bit_count), 1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 4) != 0, $urandom % 2, $urandom % 2, ($urandom % 64) == 0);
      if (n == 1500) do_reset();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_sp_deser.md
Name: reg_sp_deser

Overview:
Serial-in/parallel-out receiver. It is the far end of the MSB-first serial link driven by the team's parallel-load shift-register transmitter. Each bit is sampled when shift_en is high. Once WIDTH bits have arrived, the word is moved into an output holding register and offered through a valid/ready handshake. A sticky overflow flag reports any word dropped because the consumer stalled.

Parameters:
WIDTH, 4, data bits per word (legal range 2..32).

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
shift_in  input  1  serial data bit, sampled when shift_en=1
shift_en  input  1  bit-valid strobe; one bit per cycle when high
clear  input  1  synchronous flush of the receive path and flags
out_ready  input  1  consumer accepts parallel_out this cycle
parallel_out  output  WIDTH  completed word; first-received bit at MSB
out_valid  output  1  parallel_out holds an unconsumed word
overflow  output  1  sticky: a completed word was dropped
bit_count  output  $clog2(WIDTH+1)  bits received in the current partial word
reg_content  output  WIDTH  live view of the partial shift register
parity_err  output  1  parity result for the word in parallel_out (see Optional Feature)

Behaviour:
- Reset (reset_n=0, asynchronous) clears all state and outputs to 0: shift register, bit_count, parallel_out, out_valid, overflow, parity_err.
- States:
  - RECV: collecting data bits.
  - PAR: collecting the parity bit; exists only with the optional feature.
- Shift:
  - When shift_en=1: sreg <= {sreg[WIDTH-2:0], shift_in} and bit_count += 1.
  - reg_content = sreg at all times.
- Word completion:
  - Occurs on the shift_en cycle in which bit_count == WIDTH-1; without the feature, that is the last data bit.
  - The completed word is {sreg[WIDTH-2:0], shift_in}. On completion bit_count returns to 0.
  - Latency: parallel_out and out_valid update on the clock edge that samples the last bit, so they are visible in the following cycle.
- Handshake:
  - The word transfers when out_valid & out_ready; out_valid drops the next cycle unless a new word completes in the same cycle.
  - parallel_out is held stable while out_valid=1 and out_ready=0.
  - Completion while out_valid=0: load parallel_out and set out_valid=1.
  - Completion while out_valid=1 and out_ready=1 in the same cycle: load the new word; out_valid stays 1 with no gap.
  - Completion while out_valid=1 and out_ready=0: drop the new word, keep the old one, set overflow=1.
- overflow is sticky until clear or reset.
- clear=1 (synchronous, priority over shift_en) sets:
  - sreg, bit_count, out_valid, overflow and parity_err to 0;
  - state to RECV.
  - parallel_out keeps its value but is invalid.
- shift_en=0: all state holds, including the partial word. Gaps between bits are allowed at any position.
- Reset mid-word discards the partial word; the next shift_en bit is treated as bit 0.

Optional Feature:
- Macro: REG_SP_PARITY_EN.
- Defined:
  - After WIDTH data bits the FSM enters PAR. The next shift_en bit is the even-parity bit.
  - Word completion happens on that bit, one extra bit time.
  - parity_err = (^word) ^ parity_bit, loaded together with parallel_out and held with it.
  - The overflow and handshake rules apply unchanged at completion.
- Undefined:
  - No PAR state; completion happens on the last data bit.
  - parity_err is tied to 0.

Test Plan:
1. WIDTH=4, no macro. Shift bits 1,0,1,1 on consecutive cycles with out_ready=0.
   - Expect parallel_out=4'b1011 and out_valid=1 the cycle after the 4th bit.
   - bit_count sequence: 1,2,3,0.
2. Gapped input: bits 0,1 then shift_en=0 for 3 cycles, then bits 1,0.
   - Expect reg_content=4'b0001 during the gap.
   - Final parallel_out=4'b0110.
3. Overflow: complete 4'hA, keep out_ready=0, then shift 4'h5.
   - Expect parallel_out stays 4'hA and overflow=1.
   - After out_ready=1 for one cycle: out_valid=0, overflow remains 1.
4. Back-to-back: 4'h3 is pending; 4'hC completes in the same cycle out_ready=1.
   - Expect out_valid stays 1 and parallel_out=4'hC the next cycle.
5. clear after 2 bits, with overflow=1 and out_valid=1.
   - Next cycle: bit_count=0, out_valid=0, overflow=0.
   - The next 4 bits 1,1,1,1 give 4'hF.
6. With REG_SP_PARITY_EN:
   - Bits 1,0,1,1 then parity bit 1: parallel_out=4'hB, parity_err=0.
   - Repeat with parity bit 0: parity_err=1.
   - Also assert reset_n low mid-word: all outputs 0 immediately, without waiting for a clock edge.
